// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline control unit.
package pipe_ctrl_pkg;
  typedef logic [2:0] sel_t;
  localparam sel_t SEL_NORMAL = 3'b001;
  localparam sel_t SEL_FLUSH  = 3'b010;
  localparam sel_t SEL_STALL  = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_MEM = 2'b01;
  localparam fwd_t FWD_WB  = 2'b10;

  typedef enum logic {ST_RUN, ST_TRAP_FLUSH} state_t;

  typedef struct packed {
    logic pc_en;
    sel_t ifid;
    sel_t idex;
    sel_t exmem;
  } ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-operand forwarding comparator; MEM result wins over WB, x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_OPS = 2
) (
  input  logic [NUM_OPS-1:0][4:0] rs_ex,
  input  logic [4:0]              rd_mem,
  input  logic [4:0]              rd_wb,
  input  logic                    we_mem,
  input  logic                    we_wb,
  output logic [NUM_OPS-1:0][1:0] fwd_sel
);
  logic mem_ok, wb_ok;
  assign mem_ok = we_mem && (rd_mem != 5'd0);
  assign wb_ok  = we_wb  && (rd_wb  != 5'd0);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    always_comb begin
      fwd_sel[i] = FWD_RF;
      if (mem_ok && rd_mem == rs_ex[i])     fwd_sel[i] = FWD_MEM;
      else if (wb_ok && rd_wb == rs_ex[i])  fwd_sel[i] = FWD_WB;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/trap control: stage selects, PC enable, forwarding.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int TRAP_FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] inst_ID,
  input  logic [XLEN-1:0] inst_Ex,
  input  logic [XLEN-1:0] inst_Mem,
  input  logic [XLEN-1:0] inst_Wb,
  input  logic            reg_write_en_Mem,
  input  logic            reg_write_en_Wb,
  input  logic            branch_taken_Ex,
  input  logic            trap_req,
  input  logic            dmem_ready,
  output logic            pc_en,
  output logic            trap_pc_sel,
  output logic            trap_ack,
  output logic [2:0]      ifid_mux_sel,
  output logic [2:0]      idex_mux_sel,
  output logic [2:0]      exmem_mux_sel,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);
  localparam int CW = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(TRAP_FLUSH_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  ctrl_t         ctrl;

  logic [6:0] opc_id, opc_ex;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       load_use;

  assign opc_id = inst_ID[6:0];
  assign rs1_id = inst_ID[19:15];
  assign rs2_id = inst_ID[24:20];
  assign opc_ex = inst_Ex[6:0];
  assign rd_ex  = inst_Ex[11:7];

  assign load_use = (opc_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((uses_rs1(opc_id) && rs1_id == rd_ex) ||
                     (uses_rs2(opc_id) && rs2_id == rd_ex));

  // Freeze outranks everything, including the trap flush sequence.
  always_comb begin
    ctrl        = '{pc_en: 1'b1, ifid: SEL_NORMAL, idex: SEL_NORMAL, exmem: SEL_NORMAL};
    trap_ack    = 1'b0;
    trap_pc_sel = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (reset) begin
      ctrl = '{pc_en: 1'b0, ifid: SEL_FLUSH, idex: SEL_FLUSH, exmem: SEL_FLUSH};
    end else if (!dmem_ready) begin
      ctrl = '{pc_en: 1'b0, ifid: SEL_STALL, idex: SEL_STALL, exmem: SEL_STALL};
    end else begin
      unique case (state)
        ST_RUN: begin
          if (trap_req) begin
            ctrl        = '{pc_en: 1'b1, ifid: SEL_FLUSH, idex: SEL_FLUSH, exmem: SEL_FLUSH};
            trap_ack    = 1'b1;
            trap_pc_sel = 1'b1;
            cnt_nxt     = CNT_INIT;
            state_nxt   = (TRAP_FLUSH_CYCLES > 1) ? ST_TRAP_FLUSH : ST_RUN;
          end else if (branch_taken_Ex) begin
            ctrl = '{pc_en: 1'b1, ifid: SEL_FLUSH, idex: SEL_FLUSH, exmem: SEL_NORMAL};
          end else if (load_use) begin
            ctrl = '{pc_en: 1'b0, ifid: SEL_STALL, idex: SEL_FLUSH, exmem: SEL_NORMAL};
          end
        end
        ST_TRAP_FLUSH: begin
          ctrl    = '{pc_en: 1'b1, ifid: SEL_FLUSH, idex: SEL_FLUSH, exmem: SEL_FLUSH};
          cnt_nxt = cnt - CW'(1);
          if (cnt <= CW'(1)) state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign ifid_mux_sel  = ctrl.ifid;
  assign idex_mux_sel  = ctrl.idex;
  assign exmem_mux_sel = ctrl.exmem;

  logic [1:0][1:0] fwd_raw;
  fwd_unit #(.NUM_OPS(2)) u_fwd (
    .rs_ex   ({inst_Ex[24:20], inst_Ex[19:15]}),
    .rd_mem  (inst_Mem[11:7]),
    .rd_wb   (inst_Wb[11:7]),
    .we_mem  (reg_write_en_Mem),
    .we_wb   (reg_write_en_Wb),
    .fwd_sel (fwd_raw)
  );
  assign fwd_a_sel = reset ? FWD_RF : fwd_raw[0];
  assign fwd_b_sel = reset ? FWD_RF : fwd_raw[1];

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)                    stall_cnt <= stall_cnt + 32'd1;
      if (idex_mux_sel == SEL_FLUSH) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // Instruction bits outside the decoded fields.
  logic unused_bits;
  assign unused_bits = ^{inst_ID[XLEN-1:25], inst_ID[14:7], inst_Ex[XLEN-1:25],
                         inst_Ex[14:12], inst_Mem[XLEN-1:12], inst_Mem[6:0],
                         inst_Wb[XLEN-1:12], inst_Wb[6:0]};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int TFC  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [XLEN-1:0] inst_ID, inst_Ex, inst_Mem, inst_Wb;
  logic reg_write_en_Mem, reg_write_en_Wb, branch_taken_Ex, trap_req, dmem_ready;
  logic pc_en, trap_pc_sel, trap_ack;
  logic [2:0] ifid_mux_sel, idex_mux_sel, exmem_mux_sel;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.XLEN(XLEN), .TRAP_FLUSH_CYCLES(TFC)) dut (
    .clk(clk), .reset(reset), .inst_ID(inst_ID), .inst_Ex(inst_Ex),
    .inst_Mem(inst_Mem), .inst_Wb(inst_Wb), .reg_write_en_Mem(reg_write_en_Mem),
    .reg_write_en_Wb(reg_write_en_Wb), .branch_taken_Ex(branch_taken_Ex),
    .trap_req(trap_req), .dmem_ready(dmem_ready), .pc_en(pc_en),
    .trap_pc_sel(trap_pc_sel), .trap_ack(trap_ack), .ifid_mux_sel(ifid_mux_sel),
    .idex_mux_sel(idex_mux_sel), .exmem_mux_sel(exmem_mux_sel),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: rem = flush cycles still owed after a trap acceptance.
  int rem = 0;
  logic [31:0] m_stall = 0, m_flush = 0;
  logic e_pc, e_tps, e_ack;
  logic [2:0] e_ifid, e_idex, e_exmem;
  logic [1:0] e_fa, e_fb;
  logic [15:0] exp_v, obs;
  logic [31:0] e_stall, e_flush;

  assign obs = {pc_en, trap_pc_sel, trap_ack, ifid_mux_sel, idex_mux_sel,
                exmem_mux_sel, fwd_a_sel, fwd_b_sel};

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [6:0] ops [8] = '{7'h03, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h13};

  function automatic logic [31:0] mk(logic [6:0] opc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, opc};
  endfunction

  function automatic logic [1:0] ref_fwd(logic [4:0] rs);
    if (reg_write_en_Mem && inst_Mem[11:7] != 0 && inst_Mem[11:7] == rs) return 2'b01;
    if (reg_write_en_Wb && inst_Wb[11:7] != 0 && inst_Wb[11:7] == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    logic [4:0] rd;
    bit r1, r2;
    rd = inst_Ex[11:7];
    r1 = !(inst_ID[6:0] inside {7'h37, 7'h17, 7'h6F});
    r2 = inst_ID[6:0] inside {7'h33, 7'h23, 7'h63};
    return inst_Ex[6:0] == 7'h03 && rd != 0 &&
           ((r1 && inst_ID[19:15] == rd) || (r2 && inst_ID[24:20] == rd));
  endfunction

  task automatic set_sels(logic p, logic [2:0] a, logic [2:0] b, logic [2:0] c);
    e_pc = p; e_ifid = a; e_idex = b; e_exmem = c;
  endtask

  task automatic model_eval();
    e_tps = 0; e_ack = 0;
    if (reset)              set_sels(0, 3'b010, 3'b010, 3'b010);
    else if (!dmem_ready)   set_sels(0, 3'b100, 3'b100, 3'b100);
    else if (rem > 0)       set_sels(1, 3'b010, 3'b010, 3'b010);
    else if (trap_req) begin
      set_sels(1, 3'b010, 3'b010, 3'b010); e_tps = 1; e_ack = 1;
    end
    else if (branch_taken_Ex) set_sels(1, 3'b010, 3'b010, 3'b001);
    else if (ref_lu())        set_sels(0, 3'b100, 3'b010, 3'b001);
    else                      set_sels(1, 3'b001, 3'b001, 3'b001);
    e_fa = reset ? 2'b00 : ref_fwd(inst_Ex[19:15]);
    e_fb = reset ? 2'b00 : ref_fwd(inst_Ex[24:20]);
    exp_v = {e_pc, e_tps, e_ack, e_ifid, e_idex, e_exmem, e_fa, e_fb};
`ifdef HAZARD_PERF_CNT_EN
    e_stall = m_stall; e_flush = m_flush;
`else
    e_stall = 0; e_flush = 0;
`endif
  endtask

  task automatic tick();
    model_eval();
    if (reset) begin
      rem = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (dmem_ready) begin
        if (rem > 0) rem--;
        else if (trap_req) rem = TFC - 1;
      end
      if (!e_pc) m_stall++;
      if (e_idex == 3'b010) m_flush++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    inst_ID = NOP; inst_Ex = NOP; inst_Mem = NOP; inst_Wb = NOP;
    reg_write_en_Mem = 0; reg_write_en_Wb = 0; branch_taken_Ex = 0;
    trap_req = 0; dmem_ready = 1; reset = 0;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    inst_Ex = mk(7'h33, 5'd7, 5'd3, 5'd3); inst_Mem = mk(7'h33, 5'd3, 5'd0, 5'd0);
    reg_write_en_Mem = 1; trap_req = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs !== 16'b0_0_0_010_010_010_00_00) begin n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, 16'b0_0_0_010_010_010_00_00); end
    tick(); tick();
    idle();
    @(negedge clk); model_eval();
    n_chk++; if (stall_cnt !== 0 || flush_cnt !== 0) begin n_fail++;
      $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    n_chk++; if (obs !== exp_v) begin n_fail++;
      $display("FAIL post_reset_run got=%b exp=%b", obs, exp_v); end
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    idle();
    s0 = m_stall; f0 = m_flush;
    inst_Ex = 32'h0000_A283; inst_ID = 32'h0022_8333;
    @(negedge clk); model_eval();
    n_chk++; if (obs !== 16'b0_0_0_100_010_001_00_00) begin n_fail++;
      $display("FAIL load_use_bubble got=%b exp=%b", obs, 16'b0_0_0_100_010_001_00_00); end
    tick();
    inst_Ex = NOP; inst_Mem = 32'h0000_A283; reg_write_en_Mem = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs !== 16'b1_0_0_001_001_001_00_00) begin n_fail++;
      $display("FAIL load_use_release got=%b exp=%b", obs, 16'b1_0_0_001_001_001_00_00); end
`ifdef HAZARD_PERF_CNT_EN
    s0 = s0 + 1; f0 = f0 + 1;
`else
    s0 = 0; f0 = 0;
`endif
    n_chk++; if (stall_cnt !== s0 || flush_cnt !== f0) begin n_fail++;
      $display("FAIL load_use_perf got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, s0, f0); end
    tick();
  endtask

  task automatic test_forward();
    idle();
    inst_Ex = mk(7'h33, 5'd7, 5'd3, 5'd4);
    inst_Mem = mk(7'h33, 5'd3, 5'd0, 5'd0); inst_Wb = mk(7'h33, 5'd3, 5'd0, 5'd0);
    reg_write_en_Mem = 1; reg_write_en_Wb = 1;
    @(negedge clk); model_eval();
    n_chk++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin n_fail++;
      $display("FAIL fwd_mem_prio got=%b/%b exp=01/00", fwd_a_sel, fwd_b_sel); end
    tick();
    reg_write_en_Mem = 0; inst_Wb = mk(7'h33, 5'd3, 5'd0, 5'd0);
    @(negedge clk); model_eval();
    n_chk++; if (fwd_a_sel !== 2'b10) begin n_fail++;
      $display("FAIL fwd_wb got=%b exp=10", fwd_a_sel); end
    tick();
    reg_write_en_Mem = 1; inst_Ex = mk(7'h33, 5'd7, 5'd0, 5'd4);
    inst_Mem = mk(7'h33, 5'd0, 5'd0, 5'd0); inst_Wb = mk(7'h33, 5'd4, 5'd0, 5'd0);
    @(negedge clk); model_eval();
    n_chk++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10) begin n_fail++;
      $display("FAIL fwd_x0_and_b got=%b/%b exp=00/10", fwd_a_sel, fwd_b_sel); end
    n_chk++; if (obs !== exp_v) begin n_fail++;
      $display("FAIL fwd_model got=%b exp=%b", obs, exp_v); end
    tick();
  endtask

  task automatic test_branch_vs_lu();
    idle();
    inst_Ex = 32'h0000_A283; inst_ID = 32'h0022_8333; branch_taken_Ex = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_010_010_001) begin n_fail++;
      $display("FAIL branch_over_lu got=%b exp=%b", obs[15:4], 12'b1_0_0_010_010_001); end
    tick();
  endtask

  task automatic test_trap();
    idle(); trap_req = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_1_1_010_010_010) begin n_fail++;
      $display("FAIL trap_accept got=%b exp=%b", obs[15:4], 12'b1_1_1_010_010_010); end
    tick();
    branch_taken_Ex = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_010_010_010) begin n_fail++;
      $display("FAIL trap_flush got=%b exp=%b", obs[15:4], 12'b1_0_0_010_010_010); end
    tick();
    idle();
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_001_001_001) begin n_fail++;
      $display("FAIL trap_back_to_run got=%b exp=%b", obs[15:4], 12'b1_0_0_001_001_001); end
    tick();
  endtask

  task automatic test_freeze_trap();
    idle(); trap_req = 1;
    @(negedge clk); model_eval();
    n_chk++; if (trap_ack !== 1'b1) begin n_fail++;
      $display("FAIL freeze_trap_ack got=%b exp=1", trap_ack); end
    tick();
    trap_req = 0; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_eval();
      n_chk++; if (obs[15:4] !== 12'b0_0_0_100_100_100) begin n_fail++;
        $display("FAIL freeze_in_flush[%0d] got=%b exp=%b", i, obs[15:4], 12'b0_0_0_100_100_100); end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_010_010_010) begin n_fail++;
      $display("FAIL freeze_resume_flush got=%b exp=%b", obs[15:4], 12'b1_0_0_010_010_010); end
    tick();
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_001_001_001) begin n_fail++;
      $display("FAIL freeze_then_run got=%b exp=%b", obs[15:4], 12'b1_0_0_001_001_001); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    idle(); trap_req = 1;
    tick();
    trap_req = 0; reset = 1;
    @(negedge clk); model_eval();
    n_chk++; if (obs !== 16'b0_0_0_010_010_010_00_00) begin n_fail++;
      $display("FAIL reset_mid_flush got=%b exp=%b", obs, 16'b0_0_0_010_010_010_00_00); end
    tick();
    reset = 0;
    @(negedge clk); model_eval();
    n_chk++; if (obs[15:4] !== 12'b1_0_0_001_001_001 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_flush_run got=%b cnt=%0d/%0d exp=%b cnt=0/0",
               obs[15:4], stall_cnt, flush_cnt, 12'b1_0_0_001_001_001); end
    tick();
  endtask

  task automatic test_random(int n);
    bit pend = 0;
    for (int c = 0; c < n; c++) begin
      inst_ID  = mk(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      inst_Ex  = mk(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      inst_Mem = mk(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'd0, 5'd0);
      inst_Wb  = mk(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'd0, 5'd0);
      reg_write_en_Mem = 1'($urandom_range(1));
      reg_write_en_Wb  = 1'($urandom_range(1));
      branch_taken_Ex  = ($urandom_range(4) == 0);
      dmem_ready       = ($urandom_range(4) != 0);
      if (!pend) pend = ($urandom_range(9) == 0);
      trap_req = pend;
      reset    = ($urandom_range(49) == 0);
      @(negedge clk); model_eval();
      n_chk++; if (obs !== exp_v) begin n_fail++;
        $display("FAIL random[%0d] got=%b exp=%b", c, obs, exp_v); end
      n_chk++; if (stall_cnt !== e_stall || flush_cnt !== e_flush) begin n_fail++;
        $display("FAIL random_cnt[%0d] got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, e_stall, e_flush); end
      if (e_ack) pend = 0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch_vs_lu();
    test_trap();
    test_freeze_trap();
    test_reset_mid_flush();
    test_random(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
